// File: rtl/stepper_sequencer_if.sv
// Command and status bundle between a move controller and the stepper sequencer.
// POS_W sets the width of the signed step position.
interface stepper_sequencer_if #(
   parameter int POS_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_dir;
   logic [15:0]      cmd_steps;
   logic             abort;
   logic [2:0]       stat;
   logic             busy;
   logic             done;
   logic [POS_W-1:0] position;

   modport master (
      output cmd_valid, cmd_dir, cmd_steps, abort,
      input  cmd_ready, stat, busy, done, position
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_steps, abort,
      output cmd_ready, stat, busy, done, position
   );
endinterface

// File: rtl/stepper_sequencer.sv
// Step/direction sequencer producing the full-step phase code for the coil decoder.
// Optional macro STEPPER_HOLD_EN keeps the last phase energised while idle.
module stepper_sequencer #(
   parameter int STEP_DIV = 50000,
   parameter int POS_W    = 16
) (
   input logic clk,
   input logic rst,
   stepper_sequencer_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   logic [0:0]       state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [15:0]      rem_q, rem_d;
   logic             dir_q, dir_d;
   logic [2:0]       stat_q, stat_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic [POS_W-1:0] pos_q, pos_d;

   logic [1:0]       idxStep;
   logic [POS_W-1:0] posStep;
   logic [2:0]       statStep;
   logic [2:0]       statAbort;
   logic [2:0]       statFinal;
   logic             stepTick;

   assign idxStep  = dir_q ? idx_q + 2'd1 : idx_q - 2'd1;
   assign posStep  = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
   assign statStep = {1'b0, idxStep} + 3'd1;
   assign stepTick = (div_q == DIV_LAST);

   // What the coils see once a move ends: held phase or released
`ifdef STEPPER_HOLD_EN
   assign statAbort = stat_q;
   assign statFinal = statStep;
`else
   assign statAbort = 3'd0;
   assign statFinal = 3'd0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      div_d   = div_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      stat_d  = stat_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      pos_d   = pos_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && ready_q) begin
               if (bus.cmd_steps == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
                  rem_d   = bus.cmd_steps;
                  dir_d   = bus.cmd_dir;
                  div_d   = '0;
                  busy_d  = 1'b1;
                  ready_d = 1'b0;
                  stat_d  = {1'b0, idx_q} + 3'd1;
               end
            end
         end
         default: begin
            // A final step coinciding with abort still lands; otherwise abort wins
            if (bus.abort && !(stepTick && rem_q == 16'd1)) begin
               state_d = IDLE;
               rem_d   = '0;
               div_d   = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               stat_d  = statAbort;
            end else if (stepTick) begin
               div_d  = '0;
               idx_d  = idxStep;
               stat_d = statStep;
               pos_d  = posStep;
               rem_d  = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
                  stat_d  = statFinal;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         stat_q  <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         stat_q  <= stat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         pos_q   <= pos_d;
      end
   end

   assign bus.stat      = stat_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.cmd_ready = ready_q;
   assign bus.position  = pos_q;
endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer: one instance at STEP_DIV=4, one at STEP_DIV=1.
// Expectations follow STEPPER_HOLD_EN when the bench is built with it.
module tb_stepper_sequencer;
`ifdef STEPPER_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   stepper_sequencer_if #(.POS_W(16)) bus4 ();
   stepper_sequencer_if #(.POS_W(16)) bus1 ();

   stepper_sequencer #(.STEP_DIV(4), .POS_W(16)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   stepper_sequencer #(.STEP_DIV(1), .POS_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Offer one command to the STEP_DIV=4 instance for a single edge
   task automatic applyStimulus(input logic dir, input logic [15:0] steps);
      bus4.cmd_valid = 1'b1;
      bus4.cmd_dir   = dir;
      bus4.cmd_steps = steps;
      tick(1);
      bus4.cmd_valid = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus4.cmd_valid = 1'b0; bus4.cmd_dir = 1'b0; bus4.cmd_steps = '0; bus4.abort = 1'b0;
      bus1.cmd_valid = 1'b0; bus1.cmd_dir = 1'b0; bus1.cmd_steps = '0; bus1.abort = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);

      checkOutput("rst_stat",  32'(bus4.stat), 32'd0);
      checkOutput("rst_busy",  32'(bus4.busy), 32'd0);
      checkOutput("rst_done",  32'(bus4.done), 32'd0);
      checkOutput("rst_ready", 32'(bus4.cmd_ready), 32'd1);
      checkOutput("rst_pos",   32'(bus4.position), 32'd0);

      // Forward 3 at STEP_DIV=4, accepted at edge 0
      applyStimulus(1'b1, 16'd3);
      checkOutput("f3_e0_stat",  32'(bus4.stat), 32'd1);
      checkOutput("f3_e0_busy",  32'(bus4.busy), 32'd1);
      checkOutput("f3_e0_ready", 32'(bus4.cmd_ready), 32'd0);
      tick(3);
      checkOutput("f3_e3_stat", 32'(bus4.stat), 32'd1);
      tick(1);
      checkOutput("f3_e4_stat", 32'(bus4.stat), 32'd2);
      checkOutput("f3_e4_pos",  32'(bus4.position), 32'd1);
      tick(4);
      checkOutput("f3_e8_stat", 32'(bus4.stat), 32'd3);
      tick(3);
      checkOutput("f3_e11_done", 32'(bus4.done), 32'd0);
      tick(1);
      checkOutput("f3_e12_done",  32'(bus4.done), 32'd1);
      checkOutput("f3_e12_busy",  32'(bus4.busy), 32'd0);
      checkOutput("f3_e12_ready", 32'(bus4.cmd_ready), 32'd1);
      checkOutput("f3_e12_pos",   32'(bus4.position), 32'd3);
      checkOutput("f3_e12_stat",  32'(bus4.stat), HOLD ? 32'd4 : 32'd0);
      tick(1);
      checkOutput("f3_e13_done", 32'(bus4.done), 32'd0);
      checkOutput("f3_e13_stat", 32'(bus4.stat), HOLD ? 32'd4 : 32'd0);

      // Forward 1 from phase D wraps to phase A
      applyStimulus(1'b1, 16'd1);
      checkOutput("f1_e0_stat", 32'(bus4.stat), 32'd4);
      tick(4);
      checkOutput("f1_e4_done", 32'(bus4.done), 32'd1);
      checkOutput("f1_e4_pos",  32'(bus4.position), 32'd4);
      checkOutput("f1_e4_stat", 32'(bus4.stat), HOLD ? 32'd1 : 32'd0);

      // Zero-step command completes immediately without moving
      tick(1);
      applyStimulus(1'b1, 16'd0);
      checkOutput("z_done", 32'(bus4.done), 32'd1);
      checkOutput("z_busy", 32'(bus4.busy), 32'd0);
      checkOutput("z_stat", 32'(bus4.stat), HOLD ? 32'd1 : 32'd0);
      checkOutput("z_pos",  32'(bus4.position), 32'd4);
      tick(1);
      checkOutput("z_done_end", 32'(bus4.done), 32'd0);
      checkOutput("z_busy_end", 32'(bus4.busy), 32'd0);

      // Reverse 5 at STEP_DIV=1
      bus1.cmd_valid = 1'b1; bus1.cmd_dir = 1'b0; bus1.cmd_steps = 16'd5;
      tick(1);
      bus1.cmd_valid = 1'b0;
      checkOutput("r5_s0", 32'(bus1.stat), 32'd1);
      tick(1);
      checkOutput("r5_s1", 32'(bus1.stat), 32'd4);
      tick(1);
      checkOutput("r5_s2", 32'(bus1.stat), 32'd3);
      tick(1);
      checkOutput("r5_s3", 32'(bus1.stat), 32'd2);
      tick(1);
      checkOutput("r5_s4",   32'(bus1.stat), 32'd1);
      checkOutput("r5_done_early", 32'(bus1.done), 32'd0);
      tick(1);
      checkOutput("r5_s5",   32'(bus1.stat), HOLD ? 32'd4 : 32'd0);
      checkOutput("r5_pos",  32'(bus1.position), 32'hFFFB);
      checkOutput("r5_done", 32'(bus1.done), 32'd1);
      tick(1);
      checkOutput("r5_done_once", 32'(bus1.done), 32'd0);

      // Asynchronous reset in the middle of a move
      applyStimulus(1'b1, 16'd5);
      tick(4);
      checkOutput("mid_stat", 32'(bus4.stat), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_stat",  32'(bus4.stat), 32'd0);
      checkOutput("arst_busy",  32'(bus4.busy), 32'd0);
      checkOutput("arst_done",  32'(bus4.done), 32'd0);
      checkOutput("arst_ready", 32'(bus4.cmd_ready), 32'd1);
      checkOutput("arst_pos",   32'(bus4.position), 32'd0);
      rst = 1'b0;
      tick(1);

      // Forward 10 aborted after the second step; a pending command waits
      applyStimulus(1'b1, 16'd10);
      checkOutput("ab_e0_stat", 32'(bus4.stat), 32'd1);
      tick(8);
      checkOutput("ab_e8_stat", 32'(bus4.stat), 32'd3);
      checkOutput("ab_e8_pos",  32'(bus4.position), 32'd2);
      bus4.abort = 1'b1;
      bus4.cmd_valid = 1'b1; bus4.cmd_dir = 1'b0; bus4.cmd_steps = 16'd2;
      tick(1);
      bus4.abort = 1'b0;
      checkOutput("ab_done",  32'(bus4.done), 32'd1);
      checkOutput("ab_busy",  32'(bus4.busy), 32'd0);
      checkOutput("ab_ready", 32'(bus4.cmd_ready), 32'd1);
      checkOutput("ab_pos",   32'(bus4.position), 32'd2);
      checkOutput("ab_stat",  32'(bus4.stat), HOLD ? 32'd3 : 32'd0);
      tick(1);
      bus4.cmd_valid = 1'b0;
      checkOutput("acc_busy", 32'(bus4.busy), 32'd1);
      checkOutput("acc_done", 32'(bus4.done), 32'd0);
      checkOutput("acc_stat", 32'(bus4.stat), 32'd3);
      checkOutput("acc_pos",  32'(bus4.position), 32'd2);
      tick(4);
      checkOutput("rev_s1_stat", 32'(bus4.stat), 32'd2);
      checkOutput("rev_s1_pos",  32'(bus4.position), 32'd1);
      tick(4);
      checkOutput("rev_s2_done", 32'(bus4.done), 32'd1);
      checkOutput("rev_s2_pos",  32'(bus4.position), 32'd0);
      checkOutput("rev_s2_stat", 32'(bus4.stat), HOLD ? 32'd1 : 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
